// File: rtl/pacman_event_gen_pkg.sv
// Shared types and defaults for the Pac-Man scoring-event producer.
// Tile codes, the tile FSM states and a one-hot helper live here.
package pacman_event_gen_pkg;

  localparam int unsigned DOT_TOTAL_DEF    = 244;
  localparam int unsigned FRIGHT_TICKS_DEF = 360;

  typedef enum logic [1:0] {
    TileEmpty  = 2'd0,
    TileDot    = 2'd1,
    TilePellet = 2'd2,
    TileWall   = 2'd3
  } tile_e;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StCheck
  } tile_st_e;

  // Isolates the lowest set bit; used to pick the lowest-index ghost.
  function automatic logic [3:0] lowest_one(input logic [3:0] v);
    return v & (~v + 4'd1);
  endfunction

endpackage

// File: rtl/pacman_event_gen_fright_timer.sv
// Fright-mode timer: loads on a pellet, counts frame ticks down and
// owns the per-ghost frightened flags.
module fright_timer #(
  parameter int unsigned FRIGHT_TICKS = 360,
  parameter int unsigned TMR_W        = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       load,
  input  logic       frame_tick,
  input  logic [3:0] eat_mask,
  output logic [3:0] flags,
  output logic       active
);

  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [3:0]       flags_q, flags_d;

  always_comb begin
    tmr_d   = tmr_q;
    flags_d = flags_q & ~eat_mask;
    if (clear) begin
      tmr_d   = '0;
      flags_d = 4'h0;
    end else if (load) begin
      // A reload wins over a coincident expiry tick.
      tmr_d   = TMR_W'(FRIGHT_TICKS);
      flags_d = 4'hF;
    end else if (frame_tick && (tmr_q != '0)) begin
      tmr_d = tmr_q - 1'b1;
      if (tmr_q == TMR_W'(1)) begin
        flags_d = 4'h0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr_q   <= '0;
      flags_q <= 4'h0;
    end else begin
      tmr_q   <= tmr_d;
      flags_q <= flags_d;
    end
  end

  assign flags  = flags_q;
  assign active = (tmr_q != '0);

endmodule

// File: rtl/pacman_event_gen.sv
// Turns tile entries and ghost collisions into single-cycle scoring events,
// clearing eaten tiles in the maze RAM and tracking remaining dots.
module pacman_event_gen
  import pacman_event_gen_pkg::*;
#(
  parameter int unsigned DOT_TOTAL    = DOT_TOTAL_DEF,
  parameter int unsigned FRIGHT_TICKS = FRIGHT_TICKS_DEF,
  parameter int unsigned TMR_W        = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       game_started,
  input  logic       level_start,
  input  logic       frame_tick,
  input  logic       tile_valid,
  input  logic [4:0] pac_row,
  input  logic [4:0] pac_col,
  output logic [9:0] maze_addr,
  output logic       maze_rd_en,
  input  logic [1:0] maze_rd_data,
  output logic       maze_wr_en,
  input  logic [3:0] ghost_hit,
  output logic [3:0] ghost_frightened,
  output logic       fright_active,
  output logic       dot_collected,
  output logic       pellet_collected,
  output logic       ghost_eaten,
  output logic [1:0] ghost_eaten_count,
  output logic       lose_life,
  output logic       level_complete,
  output logic [7:0] dots_remaining
);

  tile_st_e   state_q, state_d;
  logic [9:0] addr_q, addr_d;
  logic [7:0] dots_q, dots_d;
  logic [1:0] idx_q, idx_d;
  logic       lock_q, lock_d;

  logic [3:0] flags;
  logic       active;
  logic [3:0] frightened;
  logic [3:0] eat_hit, kill_hit, eat_mask;
  logic       tile_evt;
  tile_e      code;

  assign code       = tile_e'(maze_rd_data);
  assign frightened = flags & {4{game_started}};
  assign eat_hit    = ghost_hit & frightened;
  assign kill_hit   = ghost_hit & ~frightened;

  // Tile FSM: latch address, issue one read, then act on the returned code.
  always_comb begin
    state_d          = state_q;
    addr_d           = addr_q;
    maze_rd_en       = 1'b0;
    maze_wr_en       = 1'b0;
    dot_collected    = 1'b0;
    pellet_collected = 1'b0;
    if (!game_started) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (tile_valid) begin
            addr_d  = {pac_row, pac_col};
            state_d = StRead;
          end
        end
        StRead: begin
          maze_rd_en = 1'b1;
          state_d    = StCheck;
        end
        StCheck: begin
          state_d = StIdle;
          if (code == TileDot) begin
            dot_collected = 1'b1;
            maze_wr_en    = 1'b1;
          end else if (code == TilePellet) begin
            pellet_collected = 1'b1;
            maze_wr_en       = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign tile_evt = dot_collected | pellet_collected;

  // Ghost arbitration and dot bookkeeping; tile events take the cycle.
  always_comb begin
    ghost_eaten       = 1'b0;
    ghost_eaten_count = 2'd0;
    lose_life         = 1'b0;
    eat_mask          = 4'h0;
    if (game_started && !tile_evt) begin
      if (eat_hit != 4'h0) begin
        ghost_eaten       = 1'b1;
        ghost_eaten_count = idx_q;
        eat_mask          = lowest_one(eat_hit);
      end else if ((kill_hit != 4'h0) && !lock_q) begin
        lose_life = 1'b1;
      end
    end

    level_complete = tile_evt && (dots_q == 8'd1);

    dots_d = dots_q;
    if (level_start) begin
      dots_d = 8'(DOT_TOTAL);
    end else if (tile_evt && (dots_q != 8'd0)) begin
      dots_d = dots_q - 8'd1;
    end

    idx_d = idx_q;
    if (pellet_collected) begin
      idx_d = 2'd0;
    end else if (ghost_eaten && (idx_q != 2'd3)) begin
      idx_d = idx_q + 2'd1;
    end

    lock_d = lock_q;
    if (ghost_hit == 4'h0) begin
      lock_d = 1'b0;
    end else if (lose_life) begin
      lock_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      addr_q  <= 10'd0;
      dots_q  <= 8'(DOT_TOTAL);
      idx_q   <= 2'd0;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      dots_q  <= dots_d;
      idx_q   <= idx_d;
      lock_q  <= lock_d;
    end
  end

  fright_timer #(
    .FRIGHT_TICKS (FRIGHT_TICKS),
    .TMR_W        (TMR_W)
  ) u_fright_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (level_start | ~game_started),
    .load       (pellet_collected),
    .frame_tick (frame_tick),
    .eat_mask   (eat_mask),
    .flags      (flags),
    .active     (active)
  );

  assign maze_addr        = addr_q;
  assign ghost_frightened = frightened;
  assign fright_active    = active & game_started;
  assign dots_remaining   = dots_q;

endmodule
